pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 16, width of each of the three data fields: pcp2, alu, store.
REQ-002 Parameter CTRL_W, default 2, control-bit vector width; bit 0 = RegWrite, bit 1 = RegStore.
REQ-003 Parameter RD_W, default 3, destination-register index width.
REQ-004 CLK  in  1  single clock; all state updates on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 flush  in  1  synchronous flush; invalidates all held entries.
REQ-007 in_valid  in  1  upstream has a valid payload.
REQ-008 in_ready  out  1  stage can accept a payload this cycle.
REQ-009 in_ctrl / in_rd  in  CTRL_W / RD_W  control bits and destination index.
REQ-010 in_pcp2, in_alu, in_store  in  DATA_W each  payload fields.
REQ-011 out_valid  out  1  output payload is valid.
REQ-012 out_ready  in  1  downstream accepts the output this cycle.
REQ-013 out_ctrl / out_rd / out_pcp2 / out_alu / out_store  out  same widths as inputs  held payload.

Function
REQ-014 Storage: two entries, main and skid, each holding a valid bit and the full payload.
REQ-015 Outputs: the out_* fields come directly from main; out_valid = main.valid.
REQ-016 in_ready is registered and equals !skid.valid, with no combinational path from out_ready.
REQ-017 An input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-018 Latency: an accepted payload appears on the outputs on the next edge if main is empty or main is being drained and skid is empty.
REQ-019 Sustained throughput is one payload per cycle while out_ready stays high.
REQ-020 If main is full, not draining, and an input is accepted, the payload is written into skid and skid.valid is set.
REQ-021 On an output transfer with skid.valid set, skid moves to main and skid.valid clears.
REQ-022 In the same case, a simultaneous input transfer is impossible because in_ready was 0.
REQ-023 Payload order is strictly FIFO; no payload is dropped or duplicated except by flush.
REQ-024 out_ctrl is forced to all-zero whenever out_valid = 0, so bubbles never assert RegWrite or RegStore.
REQ-025 flush: on the next edge main.valid and skid.valid clear and in_ready becomes 1.
REQ-026 Flush has priority: an input presented in the flush cycle is discarded.
REQ-027 Flush does not change the payload registers.
REQ-028 in_valid with in_ready = 0 is ignored; upstream holds the payload stable until it is accepted.

Reset
REQ-029 Reset asserted: immediately, without a clock edge, both valid bits = 0 and all payload registers = 0.
REQ-030 While Reset is asserted: out_valid = 0, out_ctrl = 0, out_rd = 0, all out_* data = 0, in_ready = 1.
REQ-031 Reset mid-transfer discards both entries; the first edge after deassertion behaves as an empty stage.

Configuration
REQ-032 Macro PIPE_STAGE_STATS_EN defined: the block adds output stall_cnt (out, 16 bits).
REQ-033 stall_cnt increments once per cycle with out_valid && !out_ready and saturates at 0xFFFF.
REQ-034 stall_cnt is cleared only by Reset; flush does not clear it.
REQ-035 Macro undefined: no stall_cnt port and no counter logic exist; all other behaviour is identical.

Structure
REQ-036 Shared package misc_pipe_pkg holds the default widths (16/2/3) and the constants CTRL_REGWRITE = 0 and CTRL_REGSTORE = 1.
REQ-037 Sub-module pipe_slot implements one entry: valid bit, payload register, load, clear, async reset.
REQ-038 pipe_stage_reg instantiates pipe_slot twice and holds the steering logic.

Verification
REQ-039 Reset test: assert Reset with no clock -> out_valid = 0, out_alu = 0x0000, in_ready = 1.
REQ-040 Streaming test: out_ready = 1, feed in_alu 0x0001..0x0008 back-to-back -> out_alu shows 0x0001..0x0008, one cycle later, no gaps.
REQ-041 Backpressure test: out_ready = 0, send 0x00A1, 0x00A2 -> in_ready = 0 after the second transfer; raise out_ready -> 0x00A1 then 0x00A2 appear in order, in_ready = 1.
REQ-042 Flush test: two entries held, in_valid = 1 with in_ctrl = 2'b11, assert flush for one cycle -> out_valid = 0, out_ctrl = 2'b00 next cycle, and that input never appears.
REQ-043 Bubble gating test: in_ctrl = 2'b01 with in_valid = 0 -> out_ctrl stays 2'b00.
REQ-044 Stats test (PIPE_STAGE_STATS_EN defined): hold out_valid = 1, out_ready = 0 for 70000 cycles -> stall_cnt = 0xFFFF; after Reset -> stall_cnt = 0.

Source files
------------

// File: rtl/misc_pipe_pkg.sv
// Shared widths and control-bit positions for pipeline stage registers.
package misc_pipe_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_CTRL_W = 2;
    localparam int DEFAULT_RD_W   = 3;

    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_REGSTORE  = 1;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline stage: a valid flag plus a payload register.
module pipe_slot
    import misc_pipe_pkg::*;
#(
    parameter int W = DEFAULT_DATA_W
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Clear wins over load so a flush always empties the entry; the payload
    // itself only changes on load.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            if (clear)
                valid <= 1'b0;
            else if (load)
                valid <= 1'b1;
            if (load)
                q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register with flush and bubble control gating.
// Optional stall counter output enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_reg
    import misc_pipe_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CTRL_W = DEFAULT_CTRL_W,
    parameter int RD_W   = DEFAULT_RD_W
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_pcp2,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_store,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_pcp2,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_store
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int PW = CTRL_W + RD_W + 3 * DATA_W;

    logic [PW-1:0]     in_bundle;
    logic [PW-1:0]     main_d;
    logic [PW-1:0]     main_q;
    logic [PW-1:0]     skid_q;
    logic              main_valid;
    logic              skid_valid;
    logic              main_load;
    logic              main_clear;
    logic              skid_load;
    logic              skid_clear;
    logic              in_fire;
    logic              out_fire;
    logic              main_free;
    logic [CTRL_W-1:0] main_ctrl;

    assign in_bundle = {in_ctrl, in_rd, in_pcp2, in_alu, in_store};

    // in_ready comes straight from the skid flag register, so out_ready never
    // reaches it combinationally.
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_valid && out_ready;
    assign main_free = !main_valid || out_fire;

    // Main refills from skid when draining with a backlog, otherwise from the
    // input; skid only catches an input that main cannot take this edge.
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_d     = skid_valid ? skid_q : in_bundle;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            if (out_fire && skid_valid) begin
                main_load  = 1'b1;
                skid_clear = 1'b1;
            end else if (in_fire && main_free) begin
                main_load = 1'b1;
            end else if (out_fire) begin
                main_clear = 1'b1;
            end
            if (in_fire && !main_free)
                skid_load = 1'b1;
        end
    end

    pipe_slot #(.W(PW)) u_main (
        .clk   (CLK),
        .Reset (Reset),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    pipe_slot #(.W(PW)) u_skid (
        .clk   (CLK),
        .Reset (Reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_bundle),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign {main_ctrl, out_rd, out_pcp2, out_alu, out_store} = main_q;

    // Bubbles must never carry RegWrite/RegStore downstream.
    assign out_ctrl = main_valid ? main_ctrl : '0;

`ifdef PIPE_STAGE_STATS_EN
    // Saturating count of cycles where a valid output was held back.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            stall_cnt <= '0;
        else if (main_valid && !out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed steps plus random traffic against a queue model.
// Stall counter checks are active when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_reg;
    import misc_pipe_pkg::*;

    localparam int DW = 16;
    localparam int CW = 2;
    localparam int RW = 3;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [RW-1:0] in_rd;
    logic [DW-1:0] in_pcp2;
    logic [DW-1:0] in_alu;
    logic [DW-1:0] in_store;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [RW-1:0] out_rd;
    logic [DW-1:0] out_pcp2;
    logic [DW-1:0] out_alu;
    logic [DW-1:0] out_store;
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0]   stall_cnt;
    int unsigned   model_stall;
`endif

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [RW-1:0] rd;
        logic [DW-1:0] pcp2;
        logic [DW-1:0] alu;
        logic [DW-1:0] store;
    } payload_t;

    payload_t model_q[$];
    int       checks   = 0;
    int       failures = 0;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .RD_W(RW)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_rd     (in_rd),
        .in_pcp2   (in_pcp2),
        .in_alu    (in_alu),
        .in_store  (in_store),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_rd    (out_rd),
        .out_pcp2  (out_pcp2),
        .out_alu   (out_alu),
        .out_store (out_store)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // The stage behaves as a FIFO of depth two: the head is on the outputs,
    // and there is room whenever fewer than two payloads are held.
    task automatic checkOutput();
        checkValue("in_ready", {31'd0, in_ready}, {31'd0, model_q.size() < 2});
        checkValue("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() > 0});
        if (model_q.size() > 0) begin
            checkValue("out_ctrl", {30'd0, out_ctrl}, {30'd0, model_q[0].ctrl});
            checkValue("out_rd", {29'd0, out_rd}, {29'd0, model_q[0].rd});
            checkValue("out_pcp2", {16'd0, out_pcp2}, {16'd0, model_q[0].pcp2});
            checkValue("out_alu", {16'd0, out_alu}, {16'd0, model_q[0].alu});
            checkValue("out_store", {16'd0, out_store}, {16'd0, model_q[0].store});
        end else begin
            checkValue("bubble_ctrl", {30'd0, out_ctrl}, 32'd0);
        end
`ifdef PIPE_STAGE_STATS_EN
        checkValue("stall_cnt", {16'd0, stall_cnt}, model_stall);
`endif
    endtask

    task automatic applyStimulus(input logic v, input logic [CW-1:0] c, input logic [RW-1:0] r,
                                 input logic [DW-1:0] p, input logic [DW-1:0] a, input logic [DW-1:0] s,
                                 input logic fl, input logic ordy);
        in_valid  = v;
        in_ctrl   = c;
        in_rd     = r;
        in_pcp2   = p;
        in_alu    = a;
        in_store  = s;
        flush     = fl;
        out_ready = ordy;
    endtask

    task automatic stepCycle();
        payload_t pl;
        logic     do_pop;
        logic     do_push;
        logic     do_flush;
        logic     stalled;
        checkOutput();
        pl       = '{ctrl: in_ctrl, rd: in_rd, pcp2: in_pcp2, alu: in_alu, store: in_store};
        do_pop   = (model_q.size() > 0) && out_ready;
        do_push  = in_valid && (model_q.size() < 2);
        do_flush = flush;
        stalled  = (model_q.size() > 0) && !out_ready;
        @(posedge CLK);
        #1;
        if (do_flush) begin
            model_q.delete();
        end else begin
            if (do_pop)
                void'(model_q.pop_front());
            if (do_push)
                model_q.push_back(pl);
        end
`ifdef PIPE_STAGE_STATS_EN
        if (stalled && model_stall < 32'hFFFF)
            model_stall++;
`else
        if (stalled) begin
        end
`endif
    endtask

    task automatic doReset();
        Reset = 1'b1;
        #1;
        model_q.delete();
        checkValue("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkValue("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkValue("rst_out_ctrl", {30'd0, out_ctrl}, 32'd0);
        checkValue("rst_out_rd", {29'd0, out_rd}, 32'd0);
        checkValue("rst_out_pcp2", {16'd0, out_pcp2}, 32'd0);
        checkValue("rst_out_alu", {16'd0, out_alu}, 32'd0);
        checkValue("rst_out_store", {16'd0, out_store}, 32'd0);
`ifdef PIPE_STAGE_STATS_EN
        model_stall = 0;
        checkValue("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
        @(negedge CLK);
        Reset = 1'b0;
        #1;
    endtask

    initial begin
        logic hold;
        applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        doReset();

        // Back-to-back stream must emerge one edge later with no gaps.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 2'b01, RW'(i), DW'(16'h1000 + i), DW'(i), DW'(16'h2000 + i), 1'b0, 1'b1);
            stepCycle();
            checkValue("stream_alu", {16'd0, out_alu}, i);
        end
        applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        repeat (2) stepCycle();

        // Backpressure fills main then skid, then drains in order.
        applyStimulus(1'b1, 2'b10, 3'd5, 16'h0011, 16'h00A1, 16'h0021, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 2'b01, 3'd6, 16'h0012, 16'h00A2, 16'h0022, 1'b0, 1'b0);
        stepCycle();
        checkValue("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        stepCycle();
        checkValue("bp_first", {16'd0, out_alu}, 32'h00A2);
        checkValue("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
        repeat (2) stepCycle();

        // Flush with both entries held and a control-heavy input waiting.
        applyStimulus(1'b1, 2'b10, 3'd1, 16'h0101, 16'h00B1, 16'h0201, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 2'b01, 3'd2, 16'h0102, 16'h00B2, 16'h0202, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 2'b11, 3'd7, 16'h0103, 16'h00B3, 16'h0203, 1'b1, 1'b0);
        stepCycle();
        checkValue("flush_valid", {31'd0, out_valid}, 32'd0);
        checkValue("flush_ctrl", {30'd0, out_ctrl}, 32'd0);
        applyStimulus(1'b0, 2'b11, '0, '0, '0, '0, 1'b0, 1'b1);
        repeat (3) stepCycle();

        // Flush with one entry held while the input would have been accepted.
        applyStimulus(1'b1, 2'b01, 3'd3, 16'h0301, 16'h00C1, 16'h0401, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 2'b11, 3'd4, 16'h0302, 16'h00C2, 16'h0402, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        repeat (2) stepCycle();

        // Control bits on an invalid input must not leak as a bubble.
        applyStimulus(1'b0, 2'b01, 3'd2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        repeat (3) stepCycle();
        checkValue("bubble_gate", {30'd0, out_ctrl}, 32'd0);

        // Reset in the middle of held traffic discards everything.
        applyStimulus(1'b1, 2'b11, 3'd1, 16'h0501, 16'h00D1, 16'h0601, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 2'b11, 3'd2, 16'h0502, 16'h00D2, 16'h0602, 1'b0, 1'b0);
        stepCycle();
        doReset();
        applyStimulus(1'b1, 2'b01, 3'd3, 16'h0503, 16'h00D3, 16'h0603, 1'b0, 1'b1);
        stepCycle();
        checkValue("post_rst_alu", {16'd0, out_alu}, 32'h00D3);

        // Random traffic; a refused input is held stable until accepted.
        hold = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!hold)
                applyStimulus(1'($urandom_range(0, 3) != 0), CW'($urandom), RW'($urandom),
                              DW'($urandom), DW'($urandom), DW'($urandom),
                              1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 7));
            else begin
                flush     = 1'($urandom_range(0, 19) == 0);
                out_ready = 1'($urandom_range(0, 9) < 7);
            end
            hold = in_valid && (model_q.size() >= 2) && !flush;
            stepCycle();
        end

`ifdef PIPE_STAGE_STATS_EN
        doReset();
        applyStimulus(1'b1, 2'b01, 3'd1, 16'h0001, 16'h00E1, 16'h0002, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        repeat (70000) stepCycle();
        checkValue("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
        applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b1, 1'b0);
        stepCycle();
        checkValue("stall_after_flush", {16'd0, stall_cnt}, 32'h0000FFFF);
        doReset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
